// File: rtl/bus_rr_sched_if.sv
// Signal bundle between the four bus masters, the shared bus strobes and the round-robin scheduler.
// All request and grant lines are active low, matching the shared bus.
interface bus_rr_sched_if;
  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic       s_as_;
  logic       m_rdy_;
  logic [1:0] owner;
  logic       busy;
  logic       bus_err;
  logic [1:0] err_master;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy, bus_err, err_master
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy, bus_err, err_master
  );
endinterface

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler for the 4-master shared bus: registered one-hot active-low grants, 1-cycle dead
// handover, MAX_XFER preemption. Define BUS_RR_SCHED_WDOG_EN to add the stalled-slave watchdog.
module bus_rr_sched #(
  parameter int unsigned MAX_XFER = 16,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          reset,
  bus_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } state_e;

  localparam logic [7:0] MAX_XFER_C = 8'(MAX_XFER);
  localparam logic [7:0] CNT_SAT_C  = (MAX_XFER == 32'd0) ? 8'hFF : 8'(MAX_XFER);

  state_e     state_q, state_d;
  logic [3:0] grnt_q, grnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] req_s;
  logic [2:0] pick_s;
  logic       xfer_s;
  logic [7:0] cnt_inc_s;
  logic       release_s;
  logic       others_s;
  logic       preempt_s;
  logic       wdog_s;
  logic       exit_s;

  // Rotating search starting after the last owner; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign req_s     = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign pick_s    = rr_pick(req_s, last_q);
  assign xfer_s    = ~bus.s_as_ & ~bus.m_rdy_;
  assign cnt_inc_s = (xfer_s && (cnt_q != CNT_SAT_C)) ? (cnt_q + 8'd1) : cnt_q;
  assign release_s = ~req_s[owner_q];
  assign others_s  = |(req_s & ~(4'b0001 << owner_q));
  assign preempt_s = (MAX_XFER_C != 8'd0) && (cnt_inc_s >= MAX_XFER_C) && others_s;
  assign exit_s    = (state_q == GRANT) && (release_s || wdog_s || preempt_s);

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_d = state_q;
    grnt_d  = grnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HANDOVER: begin
        if (pick_s[2]) begin
          state_d = GRANT;
          grnt_d  = ~(4'b0001 << pick_s[1:0]);
          owner_d = pick_s[1:0];
          last_d  = pick_s[1:0];
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          state_d = IDLE;
          grnt_d  = 4'hF;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (exit_s) begin
          state_d = HANDOVER;
          grnt_d  = 4'hF;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        grnt_d  = 4'hF;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Grant FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grnt_q  <= 4'hF;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BUS_RR_SCHED_WDOG_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] stall_q, stall_d;
  logic        stall_s;
  logic        bus_err_q, bus_err_d;
  logic [1:0]  err_master_q, err_master_d;

  assign stall_s = (state_q == GRANT) && ~bus.s_as_ && bus.m_rdy_;
  assign wdog_s  = stall_s && ((stall_q + 16'd1) == TIMEOUT_C);

  // Stall counter; a release in the same cycle wins over the watchdog and reports nothing.
  always_comb begin
    stall_d      = 16'd0;
    bus_err_d    = 1'b0;
    err_master_d = err_master_q;
    if (stall_s && !exit_s) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = 16'd0;
    end
    if (wdog_s && !release_s) begin
      bus_err_d    = 1'b1;
      err_master_d = owner_q;
    end else begin
      bus_err_d    = 1'b0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q      <= 16'd0;
      bus_err_q    <= 1'b0;
      err_master_q <= 2'd0;
    end else begin
      stall_q      <= stall_d;
      bus_err_q    <= bus_err_d;
      err_master_q <= err_master_d;
    end
  end

  assign bus.bus_err    = bus_err_q;
  assign bus.err_master = err_master_q;
`else
  assign wdog_s         = 1'b0;
  assign bus.bus_err    = 1'b0;
  assign bus.err_master = 2'd0;
`endif

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;

endmodule
